pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
- Hazard and stall sequencer for the 5-stage PA-RISC pipeline.
- Drives the load enables of PC, IF/ID, ID/EX and EX/MEM, and bubble-insert controls for ID/EX and MEM/WB.
- Sequences variable-latency data-RAM accesses in MEM through a req/ready handshake with a timeout.
- Detects EX-stage load-use hazards against the instruction in ID.

Parameters:
TIMEOUT, 15, max wait cycles in ACCESS before entering ERROR (1..2^CNT_W-1)
CNT_W, 16, width of wait counter and stall statistics counter

Ports:
clk  input  1  clock, rising edge
Reset  input  1  synchronous active-high reset
MEM_MEM_EN_in  input  1  instruction in MEM accesses data RAM (load or store)
RAM_READY_in  input  1  data RAM completes the access this cycle
EX_L_in  input  1  instruction in EX is a load
EX_RD_in  input  5  destination register of the EX instruction
ID_RA_in  input  5  source A of the ID instruction
ID_RB_in  input  5  source B of the ID instruction
ID_USES_RA_in  input  1  ID instruction reads RA
ID_USES_RB_in  input  1  ID instruction reads RB
RAM_REQ_out  output  1  request to data RAM
PC_LE_out  output  1  PC load enable
IF_ID_LE_out  output  1  IF/ID load enable
ID_EX_LE_out  output  1  ID/EX load enable
EX_MEM_LE_out  output  1  EX/MEM load enable
ID_EX_NOP_out  output  1  load a bubble into ID/EX (all control bits zero)
MEM_WB_NOP_out  output  1  load a bubble into MEM/WB
TIMEOUT_out  output  1  sticky RAM timeout error
STALL_CNT_out  output  CNT_W  saturating count of stalled cycles

Behaviour:
- FSM states: IDLE, ACCESS, ERROR. State, wait counter, stall counter and error flag are registered; all other outputs are combinational from state and inputs.
- Reset (synchronous):
  - Next state IDLE; wait counter 0; STALL_CNT_out 0; TIMEOUT_out 0.
  - While Reset=1 outputs are forced: RAM_REQ_out=0, all LE=1, ID_EX_NOP_out=1, MEM_WB_NOP_out=1.
  - Reset mid-ACCESS or in ERROR abandons the access; no further REQ until a new MEM_MEM_EN_in.
- mem_stall is 1 when:
  - in IDLE with MEM_MEM_EN_in=1 and RAM_READY_in=0; or
  - in ACCESS with RAM_READY_in=0; or
  - in ERROR.
- RAM_REQ_out = (IDLE & MEM_MEM_EN_in) | ACCESS. It is 0 in ERROR.
- IDLE transitions:
  - MEM_MEM_EN_in=1, RAM_READY_in=1: zero-wait access, no stall, stay IDLE.
  - MEM_MEM_EN_in=1, RAM_READY_in=0: go to ACCESS, wait counter <= 1.
- ACCESS transitions:
  - RAM_READY_in=1: stall released in that same cycle, go to IDLE, wait counter <= 0.
  - Else if wait counter == TIMEOUT: go to ERROR, TIMEOUT_out <= 1.
  - Else wait counter increments.
- ERROR: absorbing until Reset. The stall is held and RAM_READY_in is ignored.
- load_use = EX_L_in & (EX_RD_in != 0) & ((ID_USES_RA_in & ID_RA_in == EX_RD_in) | (ID_USES_RB_in & ID_RB_in == EX_RD_in)). R0 never hazards.
- Priority: mem_stall overrides load_use.
  - mem_stall: all four LE=0, ID_EX_NOP_out=0, MEM_WB_NOP_out=1 (MEM result withheld, bubble to WB).
  - Else load_use: PC_LE_out=0, IF_ID_LE_out=0, ID_EX_LE_out=1, ID_EX_NOP_out=1, EX_MEM_LE_out=1, MEM_WB_NOP_out=0. This is exactly one bubble, because the load advances to MEM on the next edge.
  - Else: all LE=1, both NOPs 0.
- STALL_CNT_out increments on each clock edge where (mem_stall | load_use) & !Reset. It saturates at 2^CNT_W-1 with no wrap.
- Simultaneous MEM access and load-use: mem_stall is handled first. load_use re-evaluates from held pipeline contents once the access completes.

Test Plan:
- Reset=1 for 2 cycles, then 0 with idle inputs -> all LE=1, NOPs=0, RAM_REQ_out=0, STALL_CNT_out=0, TIMEOUT_out=0.
- MEM_MEM_EN_in=1, RAM_READY_in=1 for 1 cycle -> RAM_REQ_out=1 that cycle, no stall, state stays IDLE, STALL_CNT_out=0.
- MEM_MEM_EN_in=1, RAM_READY_in low for 3 cycles then high -> RAM_REQ_out=1 and LE=0, MEM_WB_NOP_out=1 for 3 cycles; LE=1 in the 4th cycle; STALL_CNT_out=3.
- EX_L_in=1, EX_RD_in=5, ID_USES_RB_in=1, ID_RB_in=5 -> PC/IF_ID LE=0 and ID_EX_NOP_out=1 for one cycle. Repeat with EX_RD_in=0 -> no stall.
- Load-use together with a pending RAM wait of 2 cycles -> all LE=0, ID_EX_NOP_out=0 for 2 cycles, then one load-use bubble cycle.
- TIMEOUT=15 with RAM_READY_in held 0 -> ERROR after the 15th ACCESS cycle; TIMEOUT_out=1, RAM_REQ_out=0, stall persists; a later RAM_READY_in=1 is ignored; Reset clears it.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// Stall/bubble sequencer for the 5-stage pipeline: RAM wait handshake with timeout,
// EX load-use detection, and a saturating count of stalled cycles.
module pipe_stall_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             MEM_MEM_EN_in,
    input  logic             RAM_READY_in,
    input  logic             EX_L_in,
    input  logic [4:0]       EX_RD_in,
    input  logic [4:0]       ID_RA_in,
    input  logic [4:0]       ID_RB_in,
    input  logic             ID_USES_RA_in,
    input  logic             ID_USES_RB_in,
    output logic             RAM_REQ_out,
    output logic             PC_LE_out,
    output logic             IF_ID_LE_out,
    output logic             ID_EX_LE_out,
    output logic             EX_MEM_LE_out,
    output logic             ID_EX_NOP_out,
    output logic             MEM_WB_NOP_out,
    output logic             TIMEOUT_out,
    output logic [CNT_W-1:0] STALL_CNT_out
);

    typedef enum logic [1:0] {IDLE, ACCESS, ERROR} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0] scnt_q;
    logic             err_q, err_d;
    logic             mem_stall, load_use;

    assign load_use = EX_L_in && (EX_RD_in != 5'd0) &&
                      ((ID_USES_RA_in && (ID_RA_in == EX_RD_in)) ||
                       (ID_USES_RB_in && (ID_RB_in == EX_RD_in)));

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        err_d     = err_q;
        mem_stall = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (MEM_MEM_EN_in && !RAM_READY_in) begin
                    mem_stall = 1'b1;
                    state_d   = ACCESS;
                    wcnt_d    = CNT_W'(1);
                end
            end
            ACCESS: begin
                if (RAM_READY_in) begin
                    state_d = IDLE;
                    wcnt_d  = '0;
                end else begin
                    mem_stall = 1'b1;
                    if (wcnt_q == CNT_W'(TIMEOUT)) begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end else begin
                        wcnt_d = wcnt_q + CNT_W'(1);
                    end
                end
            end
            ERROR:   mem_stall = 1'b1;
            default: state_d = IDLE;
        endcase
    end

    // Output decode; reset forces a flushing bubble into both NOP-able latches.
    always_comb begin
        RAM_REQ_out    = ((state_q == IDLE) && MEM_MEM_EN_in) || (state_q == ACCESS);
        PC_LE_out      = 1'b1;
        IF_ID_LE_out   = 1'b1;
        ID_EX_LE_out   = 1'b1;
        EX_MEM_LE_out  = 1'b1;
        ID_EX_NOP_out  = 1'b0;
        MEM_WB_NOP_out = 1'b0;
        if (Reset) begin
            RAM_REQ_out    = 1'b0;
            ID_EX_NOP_out  = 1'b1;
            MEM_WB_NOP_out = 1'b1;
        end else if (mem_stall) begin
            PC_LE_out      = 1'b0;
            IF_ID_LE_out   = 1'b0;
            ID_EX_LE_out   = 1'b0;
            EX_MEM_LE_out  = 1'b0;
            MEM_WB_NOP_out = 1'b1;
        end else if (load_use) begin
            PC_LE_out     = 1'b0;
            IF_ID_LE_out  = 1'b0;
            ID_EX_NOP_out = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            scnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
            if ((mem_stall || load_use) && (scnt_q != '1))
                scnt_q <= scnt_q + CNT_W'(1);
        end
    end

    assign TIMEOUT_out   = err_q;
    assign STALL_CNT_out = scnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: a vector table for single-cycle behaviour plus
// hand sequences for timeout, ERROR absorption, reset recovery and counter saturation.
module tb_pipe_stall_ctrl;

    localparam int CNT_W = 5;   // narrow so saturation is reachable quickly

    logic clk = 1'b0;
    logic Reset;
    logic MEM_MEM_EN_in, RAM_READY_in, EX_L_in, ID_USES_RA_in, ID_USES_RB_in;
    logic [4:0] EX_RD_in, ID_RA_in, ID_RB_in;
    logic RAM_REQ_out, PC_LE_out, IF_ID_LE_out, ID_EX_LE_out, EX_MEM_LE_out;
    logic ID_EX_NOP_out, MEM_WB_NOP_out, TIMEOUT_out;
    logic [CNT_W-1:0] STALL_CNT_out;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.TIMEOUT(15), .CNT_W(CNT_W)) dut (
        .clk(clk), .Reset(Reset),
        .MEM_MEM_EN_in(MEM_MEM_EN_in), .RAM_READY_in(RAM_READY_in),
        .EX_L_in(EX_L_in), .EX_RD_in(EX_RD_in), .ID_RA_in(ID_RA_in), .ID_RB_in(ID_RB_in),
        .ID_USES_RA_in(ID_USES_RA_in), .ID_USES_RB_in(ID_USES_RB_in),
        .RAM_REQ_out(RAM_REQ_out), .PC_LE_out(PC_LE_out), .IF_ID_LE_out(IF_ID_LE_out),
        .ID_EX_LE_out(ID_EX_LE_out), .EX_MEM_LE_out(EX_MEM_LE_out),
        .ID_EX_NOP_out(ID_EX_NOP_out), .MEM_WB_NOP_out(MEM_WB_NOP_out),
        .TIMEOUT_out(TIMEOUT_out), .STALL_CNT_out(STALL_CNT_out)
    );

    // Output bundle: {REQ, PC_LE, IF_ID_LE, ID_EX_LE, EX_MEM_LE, ID_EX_NOP, MEM_WB_NOP}
    localparam logic [6:0] NORM  = 7'b0_1111_00;
    localparam logic [6:0] NORMQ = 7'b1_1111_00;
    localparam logic [6:0] MSQ   = 7'b1_0000_01;
    localparam logic [6:0] MS    = 7'b0_0000_01;
    localparam logic [6:0] LU    = 7'b0_0011_10;
    localparam logic [6:0] LUQ   = 7'b1_0011_10;
    localparam logic [6:0] RST   = 7'b0_1111_11;

    typedef struct {
        logic       en, rdy, exl;
        logic [4:0] rd, ra, rb;
        logic       ua, ub;
        logic [6:0] exp;
        logic [4:0] cnt;
        logic       to;
    } vec_t;

    vec_t tbl[17];
    int   nchk = 0;
    int   nfail = 0;

    function automatic logic [6:0] outs();
        return {RAM_REQ_out, PC_LE_out, IF_ID_LE_out, ID_EX_LE_out, EX_MEM_LE_out,
                ID_EX_NOP_out, MEM_WB_NOP_out};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        MEM_MEM_EN_in = v.en; RAM_READY_in = v.rdy; EX_L_in = v.exl;
        EX_RD_in = v.rd; ID_RA_in = v.ra; ID_RB_in = v.rb;
        ID_USES_RA_in = v.ua; ID_USES_RB_in = v.ub;
    endtask

    // Drive just after the rising edge, sample at the falling edge.
    task automatic cyc(input vec_t v);
        @(posedge clk); #1;
        drive(v);
        @(negedge clk);
    endtask

    task automatic chk_all(input string name, input logic [6:0] e, input int cnt, input logic to);
        chk({name, ".outs"}, 32'(outs()), 32'(e));
        chk({name, ".cnt"}, 32'(STALL_CNT_out), 32'(cnt));
        chk({name, ".to"}, 32'(TIMEOUT_out), 32'(to));
    endtask

    vec_t v;

    initial begin
        //           en rdy exl rd  ra  rb  ua ub exp    cnt to
        tbl[0]  = '{0, 0, 0, 0,  0,  0,  0, 0, NORM,  0, 0};
        tbl[1]  = '{1, 1, 0, 0,  0,  0,  0, 0, NORMQ, 0, 0};  // zero-wait access
        tbl[2]  = '{0, 0, 0, 0,  0,  0,  0, 0, NORM,  0, 0};  // still IDLE
        tbl[3]  = '{1, 0, 0, 0,  0,  0,  0, 0, MSQ,   0, 0};  // IDLE wait
        tbl[4]  = '{1, 0, 0, 0,  0,  0,  0, 0, MSQ,   1, 0};  // ACCESS
        tbl[5]  = '{1, 0, 0, 0,  0,  0,  0, 0, MSQ,   2, 0};
        tbl[6]  = '{1, 1, 0, 0,  0,  0,  0, 0, NORMQ, 3, 0};  // ready releases same cycle
        tbl[7]  = '{0, 0, 0, 0,  0,  0,  0, 0, NORM,  3, 0};
        tbl[8]  = '{0, 0, 1, 5,  0,  5,  0, 1, LU,    3, 0};  // RB hazard
        tbl[9]  = '{0, 0, 1, 0,  0,  0,  0, 1, NORM,  4, 0};  // R0 never hazards
        tbl[10] = '{0, 0, 1, 7,  7,  0,  1, 0, LU,    4, 0};  // RA hazard
        tbl[11] = '{0, 0, 1, 7,  7,  0,  0, 0, NORM,  5, 0};  // RA not used
        tbl[12] = '{0, 0, 0, 7,  7,  0,  1, 0, NORM,  5, 0};  // not a load
        tbl[13] = '{1, 0, 1, 5,  0,  5,  0, 1, MSQ,   5, 0};  // mem stall beats load-use
        tbl[14] = '{1, 0, 1, 5,  0,  5,  0, 1, MSQ,   6, 0};
        tbl[15] = '{1, 1, 1, 5,  0,  5,  0, 1, LUQ,   7, 0};  // access done, bubble now
        tbl[16] = '{0, 0, 0, 0,  0,  0,  0, 0, NORM,  8, 0};

        v = tbl[0];
        drive(v);
        Reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        chk_all("reset", RST, 0, 0);
        @(posedge clk); #1;
        Reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            if (i == 0) begin
                drive(tbl[0]);
                @(negedge clk);
            end else begin
                cyc(tbl[i]);
            end
            chk_all($sformatf("vec%0d", i), tbl[i].exp, int'(tbl[i].cnt), tbl[i].to);
        end

        // Timeout: 1 IDLE wait cycle + 15 ACCESS cycles, then ERROR.
        v = tbl[0]; v.en = 1'b1; v.rdy = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cyc(v);
            if (i == 0 || i == 15) chk_all($sformatf("wait%0d", i), MSQ, 8 + i, 0);
        end
        cyc(v);
        chk_all("error_entry", MS, 24, 1);
        v.rdy = 1'b1;
        cyc(v);
        chk_all("error_ready_ignored", MS, 25, 1);
        for (int i = 0; i < 10; i++) cyc(v);
        chk_all("cnt_saturate", MS, 31, 1);

        // Reset clears ERROR; no request without a new MEM access.
        @(posedge clk); #1;
        Reset = 1'b1;
        @(negedge clk);
        chk("err_reset_outs", 32'(outs()), 32'(RST));
        @(posedge clk); #1;
        Reset = 1'b0;
        drive(tbl[0]);
        @(negedge clk);
        chk_all("after_err_reset", NORM, 0, 0);

        // Reset mid-ACCESS abandons the access.
        cyc(tbl[3]);
        cyc(tbl[4]);
        chk_all("access_again", MSQ, 1, 0);
        @(posedge clk); #1;
        Reset = 1'b1;
        @(posedge clk); #1;
        Reset = 1'b0;
        drive(tbl[0]);
        @(negedge clk);
        chk_all("after_access_reset", NORM, 0, 0);
        cyc(tbl[1]);
        chk_all("zero_wait_after_reset", NORMQ, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
